// File: rtl/axi_arb_pkg.sv
// Shared types for the 2:1 AXI-lite arbiter: FSM states, grant type, port
// structs for the master-driven (Mw/Mr) and slave-driven (Sw/Sr) halves, and their zero constants.
package axi_arb_pkg;

  localparam int AXI_ADDR_WIDTH = 64;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

  // 0 selects requester m0, 1 selects requester m1
  typedef logic grant_t;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic                      awvalid;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [AXI_STRB_WIDTH-1:0] wstrb;
    logic                      wvalid;
    logic                      bready;
  } axi_mw_t;

  typedef struct packed {
    logic       awready;
    logic       wready;
    logic [1:0] bresp;
    logic       bvalid;
  } axi_sw_t;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic                      arvalid;
    logic                      rready;
  } axi_mr_t;

  typedef struct packed {
    logic                      arready;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
  } axi_sr_t;

  localparam axi_mw_t MW_ZERO = '0;
  localparam axi_sw_t SW_ZERO = '0;
  localparam axi_mr_t MR_ZERO = '0;
  localparam axi_sr_t SR_ZERO = '0;

endpackage

// File: rtl/axi_arb_pick.sv
// Two-way request picker, one per channel. With AXI_ARB_RR_EN defined a tie
// goes to the requester not granted last; otherwise m0 always wins a tie.
module axi_arb_pick
  import axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last,
  output grant_t     gnt
);

`ifdef AXI_ARB_RR_EN
  assign gnt = (&req) ? ~last : req[1];
`else
  logic unused_last;
  assign unused_last = last;
  assign gnt = req[1] & ~req[0];
`endif

endmodule

// File: rtl/axi_lite_arbiter_2to1.sv
// Shares one AXI-lite master port between m0 (fetch) and m1 (data). Write and read
// channels have independent FSMs; a grant is held until B / R completes. Macro: AXI_ARB_RR_EN.
module axi_lite_arbiter_2to1
  import axi_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rstn,
  input  axi_mw_t m0_mw,
  input  axi_mr_t m0_mr,
  output axi_sw_t m0_sw,
  output axi_sr_t m0_sr,
  input  axi_mw_t m1_mw,
  input  axi_mr_t m1_mr,
  output axi_sw_t m1_sw,
  output axi_sr_t m1_sr,
  output axi_mw_t s_mw,
  output axi_mr_t s_mr,
  input  axi_sw_t s_sw,
  input  axi_sr_t s_sr,
  output wstate_e dbg_wstate,
  output rstate_e dbg_rstate,
  output grant_t  dbg_wgnt,
  output grant_t  dbg_rgnt
);

  // Handshake rule on every channel: a beat transfers on the rising edge where
  // valid and ready are both high; valid never waits on ready.

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  grant_t  wgnt_q, wgnt_d, wlast_q, wlast_d, wpick;
  grant_t  rgnt_q, rgnt_d, rlast_q, rlast_d, rpick;
  logic    aw_done_q, aw_done_d, w_done_q, w_done_d;

  axi_mw_t wsel_mw;
  axi_mr_t rsel_mr;
  axi_sw_t wsel_sw;
  axi_sr_t rsel_sr;
  logic    aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic    aw_all, w_all;

  axi_arb_pick u_wpick (
    .req  ({m1_mw.awvalid, m0_mw.awvalid}),
    .last (wlast_q),
    .gnt  (wpick)
  );

  axi_arb_pick u_rpick (
    .req  ({m1_mr.arvalid, m0_mr.arvalid}),
    .last (rlast_q),
    .gnt  (rpick)
  );

  assign wsel_mw = wgnt_q ? m1_mw : m0_mw;
  assign rsel_mr = rgnt_q ? m1_mr : m0_mr;

  // Write routing: an already-completed AW or W beat is masked until the FSM leaves W_ADDR
  always_comb begin
    s_mw    = MW_ZERO;
    wsel_sw = SW_ZERO;
    case (wstate_q)
      W_ADDR: begin
        s_mw            = wsel_mw;
        s_mw.awvalid    = wsel_mw.awvalid & ~aw_done_q;
        s_mw.wvalid     = wsel_mw.wvalid & ~w_done_q;
        wsel_sw.awready = s_sw.awready & ~aw_done_q;
        wsel_sw.wready  = s_sw.wready & ~w_done_q;
      end
      W_RESP: begin
        s_mw.bready    = wsel_mw.bready;
        wsel_sw.bvalid = s_sw.bvalid;
        wsel_sw.bresp  = s_sw.bresp;
      end
      default: ;
    endcase
  end

  assign m0_sw = (wgnt_q == 1'b0) ? wsel_sw : SW_ZERO;
  assign m1_sw = (wgnt_q == 1'b1) ? wsel_sw : SW_ZERO;

  always_comb begin
    s_mr    = MR_ZERO;
    rsel_sr = SR_ZERO;
    case (rstate_q)
      R_ADDR: begin
        s_mr            = rsel_mr;
        rsel_sr.arready = s_sr.arready;
      end
      R_DATA: begin
        s_mr.rready    = rsel_mr.rready;
        rsel_sr.rdata  = s_sr.rdata;
        rsel_sr.rresp  = s_sr.rresp;
        rsel_sr.rvalid = s_sr.rvalid;
      end
      default: ;
    endcase
  end

  assign m0_sr = (rgnt_q == 1'b0) ? rsel_sr : SR_ZERO;
  assign m1_sr = (rgnt_q == 1'b1) ? rsel_sr : SR_ZERO;

  assign aw_hs  = s_mw.awvalid & s_sw.awready;
  assign w_hs   = s_mw.wvalid & s_sw.wready;
  assign b_hs   = (wstate_q == W_RESP) & s_sw.bvalid & s_mw.bready;
  assign ar_hs  = (rstate_q == R_ADDR) & s_mr.arvalid & s_sr.arready;
  assign r_hs   = (rstate_q == R_DATA) & s_sr.rvalid & s_mr.rready;
  assign aw_all = aw_done_q | aw_hs;
  assign w_all  = w_done_q | w_hs;

  always_comb begin
    wstate_d  = wstate_q;
    wgnt_d    = wgnt_q;
    wlast_d   = wlast_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (wstate_q)
      W_IDLE: begin
        if (m0_mw.awvalid | m1_mw.awvalid) begin
          wgnt_d   = wpick;
          wstate_d = W_ADDR;
        end
      end
      W_ADDR: begin
        if (aw_all && w_all) begin
          wstate_d  = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_all;
          w_done_d  = w_all;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wstate_d = W_IDLE;
          wlast_d  = wgnt_q;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rgnt_d   = rgnt_q;
    rlast_d  = rlast_q;
    case (rstate_q)
      R_IDLE: begin
        if (m0_mr.arvalid | m1_mr.arvalid) begin
          rgnt_d   = rpick;
          rstate_d = R_ADDR;
        end
      end
      R_ADDR: if (ar_hs) rstate_d = R_DATA;
      R_DATA: begin
        if (r_hs) begin
          rstate_d = R_IDLE;
          rlast_d  = rgnt_q;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Last-grant bits reset to m1 so the first tie goes to m0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wstate_q  <= W_IDLE;
      wgnt_q    <= 1'b0;
      wlast_q   <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rstate_q  <= R_IDLE;
      rgnt_q    <= 1'b0;
      rlast_q   <= 1'b1;
    end else begin
      wstate_q  <= wstate_d;
      wgnt_q    <= wgnt_d;
      wlast_q   <= wlast_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rstate_q  <= rstate_d;
      rgnt_q    <= rgnt_d;
      rlast_q   <= rlast_d;
    end
  end

  assign dbg_wstate = wstate_q;
  assign dbg_rstate = rstate_q;
  assign dbg_wgnt   = wgnt_q;
  assign dbg_rgnt   = rgnt_q;

endmodule
